// File: rtl/joint_scan_pkg.sv
// Shared types and constants for the joint scan controller: FSM state encoding
// and the default joint position limits (10-bit ADC scale).
package joint_scan_pkg;

    localparam int POS_W = 10;

    localparam logic [POS_W-1:0] DEF_MIN_POS = 10'd228;
    localparam logic [POS_W-1:0] DEF_CENTER  = 10'd529;
    localparam logic [POS_W-1:0] DEF_MAX_POS = 10'd830;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_UPDATE,
        S_NEXT
    } scan_state_e;

endpackage

// File: rtl/joint_scan_ctrl_pos_step.sv
// Combinational position update: clamp the sample, apply the deadband and move
// the joint one STEP toward the stick, saturating at the travel limits.
module pos_step
    import joint_scan_pkg::*;
#(
    parameter logic [POS_W-1:0] MIN_POS   = DEF_MIN_POS,
    parameter logic [POS_W-1:0] MAX_POS   = DEF_MAX_POS,
    parameter logic [POS_W-1:0] CENTER    = DEF_CENTER,
    parameter logic [POS_W-1:0] DEAD_BAND = 10'd30,
    parameter logic [POS_W-1:0] STEP      = 10'd4
) (
    input  logic [POS_W-1:0] sample,
    input  logic [POS_W-1:0] pos,
    output logic [POS_W-1:0] new_pos
);

    logic [POS_W:0] s_clamped;
    logic [POS_W:0] hi_edge;
    logic [POS_W:0] lo_edge;
    logic [POS_W:0] pos_up;
    logic [POS_W:0] down_floor;

    // One extra bit on every intermediate keeps sums and band edges from wrapping.
    always_comb begin
        if (sample < MIN_POS) begin
            s_clamped = {1'b0, MIN_POS};
        end else if (sample > MAX_POS) begin
            s_clamped = {1'b0, MAX_POS};
        end else begin
            s_clamped = {1'b0, sample};
        end

        hi_edge    = {1'b0, CENTER} + {1'b0, DEAD_BAND};
        lo_edge    = {1'b0, CENTER} - {1'b0, DEAD_BAND};
        pos_up     = {1'b0, pos} + {1'b0, STEP};
        down_floor = {1'b0, MIN_POS} + {1'b0, STEP};

        new_pos = pos;
        if (s_clamped > hi_edge) begin
            new_pos = (pos_up > {1'b0, MAX_POS}) ? MAX_POS : pos_up[POS_W-1:0];
        end else if (s_clamped < lo_edge) begin
            new_pos = ({1'b0, pos} < down_floor) ? MIN_POS : (pos - STEP);
        end
    end

endmodule

// File: rtl/joint_scan_ctrl.sv
// Periodic joystick scanner: one ADC conversion per joint each tick, stepping
// every joint position. Define ADC_TIMEOUT_EN to bound the wait for adc_done.
module joint_scan_ctrl
    import joint_scan_pkg::*;
#(
    parameter int               NUM_JOINTS = 4,
    parameter logic [POS_W-1:0] MIN_POS    = DEF_MIN_POS,
    parameter logic [POS_W-1:0] MAX_POS    = DEF_MAX_POS,
    parameter logic [POS_W-1:0] CENTER     = DEF_CENTER,
    parameter logic [POS_W-1:0] DEAD_BAND  = 10'd30,
    parameter logic [POS_W-1:0] STEP       = 10'd4,
    parameter int               TICK_DIV   = 50000,
    parameter int               TIMEOUT    = 1023
) (
    input  logic                        CLK,
    input  logic                        SW1_N,
    output logic                        adc_start,
    output logic [2:0]                  adc_ch,
    input  logic                        adc_done,
    input  logic [POS_W-1:0]            adc_data,
    output logic [NUM_JOINTS*POS_W-1:0] o_pos,
    output logic                        o_update,
    output logic                        o_busy,
    output logic                        o_overrun,
    output logic                        o_err
);

    localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
`ifdef ADC_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;

    // Reset asserts asynchronously but releases only after two CLK edges.
    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge CLK or negedge SW1_N) begin
        if (!SW1_N) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n = rst_sync_q[1];

    scan_state_e       state_q, state_d;
    logic [2:0]        j_q, j_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [POS_W-1:0]  sample_q, sample_d;
    logic [POS_W-1:0]  pos_q [NUM_JOINTS];
    logic [POS_W-1:0]  pos_d [NUM_JOINTS];
    logic              start_q, start_d;
    logic              update_q, update_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic              err_q, err_d;
    logic              tick;
    logic [POS_W-1:0]  pos_cur;
    logic [POS_W-1:0]  pos_next;

    assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

    always_comb begin
        pos_cur = pos_q[0];
        for (int i = 0; i < NUM_JOINTS; i++) begin
            if (j_q == 3'(i)) pos_cur = pos_q[i];
        end
    end

    pos_step #(
        .MIN_POS  (MIN_POS),
        .MAX_POS  (MAX_POS),
        .CENTER   (CENTER),
        .DEAD_BAND(DEAD_BAND),
        .STEP     (STEP)
    ) u_pos_step (
        .sample (sample_q),
        .pos    (pos_cur),
        .new_pos(pos_next)
    );

    always_comb begin
        state_d   = state_q;
        j_d       = j_q;
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        wait_d    = wait_q;
        sample_d  = sample_q;
        pos_d     = pos_q;
        start_d   = 1'b0;
        update_d  = 1'b0;
        err_d     = err_q;
        // A tick that lands mid-scan is dropped, never queued.
        overrun_d = overrun_q | (tick && (state_q != S_IDLE));

        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_START;
                    j_d     = 3'd0;
                    start_d = 1'b1;
                end
            end
            S_START: begin
                state_d = S_WAIT;
                wait_d  = '0;
            end
            S_WAIT: begin
                if (adc_done) begin
                    sample_d = adc_data;
                    state_d  = S_UPDATE;
                end else if (TIMEOUT_EN && (wait_q == WAIT_W'(TIMEOUT - 1))) begin
                    err_d   = 1'b1;
                    state_d = S_NEXT;
                end else if (TIMEOUT_EN) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_UPDATE: begin
                for (int i = 0; i < NUM_JOINTS; i++) begin
                    if (j_q == 3'(i)) pos_d[i] = pos_next;
                end
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (j_q == 3'(NUM_JOINTS - 1)) begin
                    state_d  = S_IDLE;
                    update_d = 1'b1;
                end else begin
                    j_d     = j_q + 3'd1;
                    state_d = S_START;
                    start_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            j_q       <= 3'd0;
            cnt_q     <= '0;
            wait_q    <= '0;
            sample_q  <= CENTER;
            for (int i = 0; i < NUM_JOINTS; i++) pos_q[i] <= CENTER;
            start_q   <= 1'b0;
            update_q  <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            j_q       <= j_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            sample_q  <= sample_d;
            pos_q     <= pos_d;
            start_q   <= start_d;
            update_q  <= update_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            err_q     <= err_d;
        end
    end

    for (genvar g = 0; g < NUM_JOINTS; g++) begin : g_pos
        assign o_pos[POS_W*g +: POS_W] = pos_q[g];
    end

    assign adc_start = start_q;
    assign adc_ch    = j_q;
    assign o_update  = update_q;
    assign o_busy    = busy_q;
    assign o_overrun = overrun_q;
    assign o_err     = err_q;

endmodule

// File: doc/joint_scan_ctrl.md
JOINT_SCAN_CTRL -- requirements
Module: joint_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_JOINTS, default 4: joints scanned; 2..8.
REQ-002 SHALL have parameter MIN_POS, default 10'd228: lower clamp of every joint position.
REQ-003 SHALL have parameter MAX_POS, default 10'd830: upper clamp of every joint position.
REQ-004 SHALL have parameter CENTER, default 10'd529: joystick midpoint and reset position.
REQ-005 SHALL have parameter DEAD_BAND, default 10'd30: half-width of the no-move band around CENTER.
REQ-006 SHALL have parameter STEP, default 10'd4: position change per scan when outside the band.
REQ-007 SHALL have parameter TICK_DIV, default 50000: CLK cycles per scan period.
REQ-008 SHALL have parameter TIMEOUT, default 1023: maximum WAIT cycles (only used with ADC_TIMEOUT_EN).
REQ-009 SHALL have port CLK, input, 1 bit: the single clock; all logic on the rising edge.
REQ-010 SHALL have port SW1_N, input, 1 bit: asynchronous active-low reset.
REQ-011 SHALL have port adc_start, output, 1 bit: one-cycle conversion request.
REQ-012 SHALL have port adc_ch, output, 3 bits: ADC channel, which equals the current joint index.
REQ-013 SHALL have port adc_done, input, 1 bit: conversion complete, valid with adc_data.
REQ-014 SHALL have port adc_data, input, 10 bits: raw joystick sample.
REQ-015 SHALL have port o_pos, output, NUM_JOINTS*10 bits: joint j held in bits [10j+9:10j].
REQ-016 SHALL have port o_update, output, 1 bit: one-cycle pulse when a full scan completes.
REQ-017 SHALL have port o_busy, output, 1 bit: high while the FSM is not in IDLE.
REQ-018 SHALL have port o_overrun, output, 1 bit: sticky flag, set when a tick arrives while busy.
REQ-019 SHALL have port o_err, output, 1 bit: sticky ADC timeout flag.

Function
REQ-020 SHALL run a free tick counter 0..TICK_DIV-1; a tick is asserted in the cycle the counter wraps to 0.
REQ-021 SHALL implement FSM states IDLE, START, WAIT, UPDATE, NEXT.
REQ-022 IDLE SHALL go to START with joint index j=0 on a tick; otherwise it SHALL remain in IDLE.
REQ-023 START SHALL assert adc_start for exactly one cycle with adc_ch=j, then go to WAIT.
REQ-024 WAIT SHALL latch adc_data on adc_done and go to UPDATE the next cycle.
REQ-025 adc_done outside WAIT SHALL be ignored, including a done in the same cycle as START.
REQ-026 UPDATE SHALL first clamp the sample s to [MIN_POS, MAX_POS].
REQ-027 UPDATE: if s > CENTER+DEAD_BAND, pos[j] SHALL become min(pos[j]+STEP, MAX_POS).
REQ-028 UPDATE: if s < CENTER-DEAD_BAND, pos[j] SHALL become max(pos[j]-STEP, MIN_POS).
REQ-029 UPDATE: otherwise pos[j] SHALL hold; s exactly equal to either band edge SHALL hold.
REQ-030 UPDATE arithmetic SHALL use 11-bit intermediates so that no wrap-around occurs.
REQ-031 NEXT: if j==NUM_JOINTS-1, SHALL go to IDLE and pulse o_update; else j SHALL increment and the FSM SHALL go to START.
REQ-032 A tick while not in IDLE SHALL be dropped and SHALL set o_overrun.
REQ-033 The dropped scan SHALL NOT be queued.
REQ-034 o_pos SHALL change only in the cycle after UPDATE and only for joint j.
REQ-035 Minimum per-joint latency SHALL be 4 cycles: START, WAIT (done on first cycle), UPDATE, NEXT.

Reset
REQ-036 Assertion of SW1_N low SHALL immediately force state=IDLE, j=0, tick counter=0, every pos=CENTER, and adc_start, o_update, o_busy, o_overrun, o_err = 0.
REQ-037 Reset mid-scan SHALL abandon the conversion; a late adc_done after release SHALL be ignored because the FSM is in IDLE.
REQ-038 Deassertion SHALL be synchronised to CLK using a 2-flop release.

Configuration
REQ-039 Macro ADC_TIMEOUT_EN defined: a WAIT cycle counter reaching TIMEOUT SHALL set o_err, hold pos[j] and go to NEXT.
REQ-040 ADC_TIMEOUT_EN undefined: WAIT SHALL wait indefinitely and o_err SHALL be tied to 0.

Structure
REQ-041 Package joint_scan_pkg SHALL hold the FSM state enum, the default position constants (228/529/830) and POS_W=10.
REQ-042 Sub-module pos_step SHALL contain the combinational clamp/deadband/step logic, instantiated once and shared across joints.

Verification
REQ-043 Scenario: after reset, 1 scan with adc_data=529 for all channels -> o_pos all 529, one o_update pulse, adc_ch sequence 0,1,2,3.
REQ-044 Scenario: adc_data=900 for 200 scans on joint 0 -> pos0 steps +4 per scan, saturates at 830, and never exceeds it.
REQ-045 Scenario: adc_data=559 then 499 (band edges) -> pos unchanged; 560 -> +4; 498 -> -4.
REQ-046 Scenario: adc_done delayed beyond TICK_DIV -> o_overrun=1, next scan starts at the first tick after IDLE.
REQ-047 Scenario: with ADC_TIMEOUT_EN, joint 2 never gets done -> o_err=1 after 1023 WAIT cycles, pos2 held, joint 3 still scanned.
REQ-048 Scenario: SW1_N pulsed low during WAIT on joint 1 -> all pos=529 and IDLE; a stray adc_done after release -> no change.
